// File: rtl/cassette_recorder.sv
// Oric tape-out recorder: measures cycle periods, frames bits into
// bytes (start, 8 data LSB first, odd parity, stop) and writes them out.
module cassette_recorder #(
  parameter int          MIN_PERIOD = 4800,
  parameter int          BIT_THRESH = 12480,
  parameter int          MAX_PERIOD = 24000,
  parameter logic [15:0] ADDR_LAST  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clear,
  input  logic        tape_in,
  output logic [15:0] tape_addr,
  output logic [7:0]  tape_wr_data,
  output logic        tape_wr,
  output logic [15:0] tape_len,
  output logic        full,
  output logic [7:0]  parity_err_cnt
);

  typedef enum logic [2:0] {
    IDLE, HUNT, DATA, PARITY, STOP
  } state_t;

  localparam logic [15:0] MAXC = 16'(MAX_PERIOD);
  localparam logic [16:0] MINP = 17'(MIN_PERIOD);
  localparam logic [16:0] THRP = 17'(BIT_THRESH);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  sync;
  logic [15:0] cnt;
  logic [16:0] per;
  logic        armed;
  logic        rise;
  logic        active;
  logic        bit_v;
  logic        bit_val;
  logic        lost;
  logic        commit;
  logic [7:0]  shreg;
  logic [2:0]  idx;
  logic        par_bad;
  logic        pend;
  logic        pend_perr;

  // Period of the cycle that ends at this clock's edge, counting
  // both edge clocks once.
  assign per     = {1'b0, cnt} + 17'd1;
  assign rise    = sync[1] & ~sync[2];
  assign active  = en & (state != IDLE);
  assign bit_v   = active & armed & rise & (per >= MINP);
  assign bit_val = per < THRP;
  assign lost    = active & armed & ~rise & (cnt == MAXC);
  assign commit  = en & (state == STOP) & bit_v & bit_val;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], tape_in};
  end

  // Period counter; glitch edges leave it running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise && !(armed && per < MINP)) begin
      cnt <= '0;
    end else if (cnt != MAXC) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Edge reference: first edge arms, carrier loss or idle disarms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        armed <= 1'b0;
    else if (!active) armed <= 1'b0;
    else if (lost)    armed <= 1'b0;
    else if (rise)    armed <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else if (lost) begin
      state_nx = HUNT;
    end else begin
      unique case (state)
        IDLE:   state_nx = HUNT;
        HUNT:   if (bit_v && !bit_val) state_nx = DATA;
        DATA:   if (bit_v && idx == 3'd7) state_nx = PARITY;
        PARITY: if (bit_v) state_nx = STOP;
        STOP:   if (bit_v) state_nx = HUNT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Byte assembly and parity check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      idx     <= '0;
      par_bad <= 1'b0;
    end else if (bit_v) begin
      if (state == HUNT && !bit_val) idx <= '0;
      if (state == DATA) begin
        shreg <= {bit_val, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
      if (state == PARITY) par_bad <= ~(^shreg ^ bit_val);
    end
  end

  // Write strobe, issued the clock after stop-bit classification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tape_wr      <= 1'b0;
      tape_wr_data <= '0;
      pend         <= 1'b0;
      pend_perr    <= 1'b0;
    end else begin
      tape_wr   <= commit & ~full & ~clear;
      pend      <= commit & ~clear;
      pend_perr <= par_bad;
      if (commit) tape_wr_data <= shreg;
    end
  end

  // Address, length, full flag and parity error count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tape_addr      <= '0;
      tape_len       <= '0;
      full           <= 1'b0;
      parity_err_cnt <= '0;
    end else if (clear) begin
      tape_addr      <= '0;
      tape_len       <= '0;
      full           <= 1'b0;
      parity_err_cnt <= '0;
    end else if (pend) begin
      if (pend_perr && parity_err_cnt != 8'hFF)
        parity_err_cnt <= parity_err_cnt + 8'd1;
      if (!full) begin
        tape_len <= tape_len + 16'd1;
        if (tape_addr == ADDR_LAST) full <= 1'b1;
        else                        tape_addr <= tape_addr + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder with scaled-down timing.
// Tape waveforms are synthesised from bit lists; writes are logged.
module tb_cassette_recorder;

  localparam int ONE  = 100;
  localparam int ZERO = 150;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        clear;
  logic        tape_in;
  logic [15:0] tape_addr;
  logic [7:0]  tape_wr_data;
  logic        tape_wr;
  logic [15:0] tape_len;
  logic        full;
  logic [7:0]  parity_err_cnt;

  int ncmp = 0;
  int nerr = 0;
  int wcnt = 0;
  logic [15:0] wa [64];
  logic [7:0]  wd [64];

  cassette_recorder #(
    .MIN_PERIOD(48),
    .BIT_THRESH(125),
    .MAX_PERIOD(240),
    .ADDR_LAST(16'h0003)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .clear(clear),
    .tape_in(tape_in),
    .tape_addr(tape_addr),
    .tape_wr_data(tape_wr_data),
    .tape_wr(tape_wr),
    .tape_len(tape_len),
    .full(full),
    .parity_err_cnt(parity_err_cnt)
  );

  always #5 clk = ~clk;

  // Write log
  always @(negedge clk) begin
    if (tape_wr) begin
      if (wcnt < 64) begin
        wa[wcnt] = tape_addr;
        wd[wcnt] = tape_wr_data;
      end
      wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input int i, input logic [15:0] a,
                           input logic [7:0] d);
    chk("wr_addr", {16'h0, wa[i]}, {16'h0, a});
    chk("wr_data", {24'h0, wd[i]}, {24'h0, d});
  endtask

  task automatic period(input int len);
    tape_in = 1'b1;
    repeat (len / 2) @(negedge clk);
    tape_in = 1'b0;
    repeat (len - len / 2) @(negedge clk);
  endtask

  task automatic period_glitch(input int len);
    tape_in = 1'b1;
    repeat (10) @(negedge clk);
    tape_in = 1'b0;
    repeat (10) @(negedge clk);
    tape_in = 1'b1;
    repeat (10) @(negedge clk);
    tape_in = 1'b0;
    repeat (len - 30) @(negedge clk);
  endtask

  task automatic leader(input int n);
    repeat (n) period(ONE);
  endtask

  task automatic data_bits(input logic [7:0] d, input int gbit);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) period_glitch(ONE);
      else           period(d[i] ? ONE : ZERO);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit flip = 1'b0,
                           input bit stop = 1'b1, input int gbit = -1);
    logic par;
    par = ~^d ^ flip;
    period(ZERO);
    data_bits(d, gbit);
    period(par ? ONE : ZERO);
    period(stop ? ONE : ZERO);
    period(ONE);
  endtask

  // Stop bit is closed by an edge whose classification clock sees clear.
  task automatic send_byte_clr(input logic [7:0] d);
    period(ZERO);
    data_bits(d, -1);
    period(~^d ? ONE : ZERO);
    period(ONE);
    tape_in = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (ONE / 2 - 3) @(negedge clk);
    tape_in = 1'b0;
    repeat (ONE - ONE / 2) @(negedge clk);
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    clear   = 1'b0;
    tape_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", {16'h0, tape_addr}, 32'h0);
    chk("rst_len", {16'h0, tape_len}, 32'h0);
    chk("rst_wr", {31'h0, tape_wr}, 32'h0);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_perr", {24'h0, parity_err_cnt}, 32'h0);
    reset = 1'b0;
    en    = 1'b1;
    @(negedge clk);

    // Leader then one byte
    leader(64);
    send_byte(8'h16);
    chk("t1_wcnt", wcnt, 1);
    chk_write(0, 16'h0, 8'h16);
    chk("t1_len", {16'h0, tape_len}, 32'h1);
    chk("t1_addr", {16'h0, tape_addr}, 32'h1);

    pulse_clear;
    chk("clr_addr", {16'h0, tape_addr}, 32'h0);
    chk("clr_len", {16'h0, tape_len}, 32'h0);

    // Byte sequence, filling the cache
    leader(4);
    send_byte(8'h16);
    send_byte(8'h16);
    send_byte(8'h24);
    send_byte(8'h00);
    chk("t2_wcnt", wcnt, 5);
    chk_write(1, 16'h0, 8'h16);
    chk_write(2, 16'h1, 8'h16);
    chk_write(3, 16'h2, 8'h24);
    chk_write(4, 16'h3, 8'h00);
    chk("t2_len", {16'h0, tape_len}, 32'h4);
    chk("t2_perr", {24'h0, parity_err_cnt}, 32'h0);
    chk("t2_full", {31'h0, full}, 32'h1);
    chk("t2_addr", {16'h0, tape_addr}, 32'h3);

    // Byte while full, with bad parity
    send_byte(8'h5A, 1'b1);
    chk("t5_wcnt", wcnt, 5);
    chk("t5_len", {16'h0, tape_len}, 32'h4);
    chk("t5_addr", {16'h0, tape_addr}, 32'h3);
    chk("t5_perr", {24'h0, parity_err_cnt}, 32'h1);

    pulse_clear;
    chk("clr_full", {31'h0, full}, 32'h0);
    chk("clr_perr", {24'h0, parity_err_cnt}, 32'h0);

    // Parity error, then framing error
    leader(3);
    send_byte(8'h55, 1'b1);
    chk("t3_wcnt", wcnt, 6);
    chk_write(5, 16'h0, 8'h55);
    chk("t3_perr", {24'h0, parity_err_cnt}, 32'h1);
    send_byte(8'h55, 1'b0, 1'b0);
    chk("t3_frm_wcnt", wcnt, 6);
    send_byte(8'h24);
    chk("t3_next_wcnt", wcnt, 7);
    chk_write(6, 16'h1, 8'h24);
    chk("t3_len", {16'h0, tape_len}, 32'h2);

    // Glitch mid-byte
    send_byte(8'h16, 1'b0, 1'b1, 1);
    chk("t4_glitch_wcnt", wcnt, 8);
    chk_write(7, 16'h2, 8'h16);

    // Carrier loss mid-byte
    period(ZERO);
    leader(3);
    tape_in = 1'b0;
    repeat (300) @(negedge clk);
    chk("t4_lost_wcnt", wcnt, 8);
    leader(3);
    send_byte(8'h00);
    chk("t4_after_wcnt", wcnt, 9);
    chk_write(8, 16'h3, 8'h00);
    chk("t4_full", {31'h0, full}, 32'h1);
    chk("t4_len", {16'h0, tape_len}, 32'h4);

    pulse_clear;

    // Reset mid-byte
    leader(3);
    send_byte(8'hA5);
    chk("t6_wcnt", wcnt, 10);
    chk_write(9, 16'h0, 8'hA5);
    period(ZERO);
    leader(2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_rst_addr", {16'h0, tape_addr}, 32'h0);
    chk("t6_rst_len", {16'h0, tape_len}, 32'h0);
    chk("t6_rst_data", {24'h0, tape_wr_data}, 32'h0);
    chk("t6_rst_wr", {31'h0, tape_wr}, 32'h0);
    reset = 1'b0;
    leader(3);
    send_byte(8'h3C);
    chk("t6_post_rst_wcnt", wcnt, 11);
    chk_write(10, 16'h0, 8'h3C);

    // Enable dropped mid-byte
    period(ZERO);
    leader(3);
    en = 1'b0;
    leader(5);
    period(ONE);
    period(ONE);
    period(ONE);
    chk("t6_en_wcnt", wcnt, 11);
    chk("t6_en_addr", {16'h0, tape_addr}, 32'h1);
    en = 1'b1;
    leader(3);
    send_byte(8'h81);
    chk("t6_en_next_wcnt", wcnt, 12);
    chk_write(11, 16'h1, 8'h81);
    chk("t6_en_addr2", {16'h0, tape_addr}, 32'h2);

    // Clear coincident with commit
    send_byte_clr(8'hC3);
    chk("t6_clr_wcnt", wcnt, 12);
    chk("t6_clr_addr", {16'h0, tape_addr}, 32'h0);
    chk("t6_clr_len", {16'h0, tape_len}, 32'h0);
    send_byte(8'h7E);
    chk("t6_final_wcnt", wcnt, 13);
    chk_write(12, 16'h0, 8'h7E);
    chk("t6_final_len", {16'h0, tape_len}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
